// File: rtl/popcount_neuron_acc.sv
// Streaming popcount neuron: counts set bits per beat, accumulates a frame with
// saturation (exact or LSB-truncated), and presents sum + fire bit on a held handshake.
module popcount_neuron_acc #(
  parameter int WIDTH       = 18,
  parameter int ACC_W       = 8,
  parameter int APPROX_DROP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [ACC_W-1:0] thresh,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_fire,
  output logic             out_sat
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] DROP_MASK = CW'(~((32'd1 << APPROX_DROP) - 32'd1));
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  generate
    if (ACC_W < CW) begin : g_param_check
      $error("popcount_neuron_acc: ACC_W must be >= clog2(WIDTH+1)");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic             accept;
  logic             mode_eff;
  logic [CW-1:0]    beat_cnt;
  logic [CW-1:0]    cnt_q;
  logic             cnt_v_q;
  logic [ACC_W-1:0] acc_q;
  logic             sat_q;
  logic [ACC_W-1:0] thresh_q;
  logic             mode_q;
  logic [ACC_W:0]   sum_wide;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] d);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CW'(d[i]);
    return c;
  endfunction

  assign accept = in_valid && in_ready;

  // The first beat of a frame must use the mode being captured on that same edge.
  assign mode_eff = (state_q == S_IDLE) ? approx_en : mode_q;
  assign beat_cnt = mode_eff ? (popcount(in_data) & DROP_MASK) : popcount(in_data);
  assign sum_wide = {1'b0, acc_q} + (ACC_W+1)'(cnt_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned
  // (otherwise synthesis infers a latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = in_last ? S_DRAIN : S_ACC;
      S_ACC:   if (accept && in_last) state_d = S_DRAIN;
      S_DRAIN: state_d = S_OUT;
      S_OUT:   if (out_valid && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE) || (state_q == S_ACC);
  end

  // Stage 1: registered per-beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      cnt_v_q <= 1'b0;
    end else begin
      cnt_v_q <= accept;
      if (accept) cnt_q <= beat_cnt;
    end
  end

  // Stage 2: saturating accumulator plus per-frame captured controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      sat_q    <= 1'b0;
      thresh_q <= '0;
      mode_q   <= 1'b0;
    end else if (state_q == S_IDLE && accept) begin
      acc_q    <= '0;
      sat_q    <= 1'b0;
      thresh_q <= thresh;
      mode_q   <= approx_en;
    end else if (cnt_v_q) begin
      if (sum_wide[ACC_W]) begin
        acc_q <= ACC_MAX;
        sat_q <= 1'b1;
      end else begin
        acc_q <= sum_wide[ACC_W-1:0];
      end
    end
  end

  // Result register: loaded once on entering OUT, then held until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_fire  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (state_q == S_OUT && !out_valid) begin
      out_valid <= 1'b1;
      out_sum   <= acc_q;
      out_fire  <= (acc_q >= thresh_q);
      out_sat   <= sat_q;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_popcount_neuron_acc.sv
// Directed bench for popcount_neuron_acc: default instance (ACC_W=8) and a
// narrow ACC_W=5 instance fed the same stream to exercise saturation.
module tb_popcount_neuron_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, approx_en, out_ready;
  logic [17:0] in_data;
  logic [7:0]  thresh;
  logic [4:0]  thresh5;
  logic        in_ready, out_valid, out_fire, out_sat;
  logic [7:0]  out_sum;
  logic        s5_in_ready, s5_out_valid, s5_out_fire, s5_out_sat;
  logic [4:0]  s5_out_sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  popcount_neuron_acc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .thresh(thresh), .approx_en(approx_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_fire(out_fire), .out_sat(out_sat)
  );

  popcount_neuron_acc #(.WIDTH(18), .ACC_W(5), .APPROX_DROP(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s5_in_ready),
    .in_data(in_data), .in_last(in_last), .thresh(thresh5), .approx_en(approx_en),
    .out_valid(s5_out_valid), .out_ready(out_ready), .out_sum(s5_out_sum),
    .out_fire(s5_out_fire), .out_sat(s5_out_sat)
  );

  typedef struct {
    int          n;
    logic [17:0] data [4];
    logic        apx  [4];
    logic [7:0]  thr  [4];
    int          exp_sum;
    logic        exp_fire;
    logic        exp_sat;
    int          exp5_sum;
    logic        exp5_fire;
    logic        exp5_sat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic beat(input logic [17:0] d, input logic last, input logic apx,
                      input logic [7:0] thr);
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    approx_en = apx;
    thresh    = thr;
    check("in_ready_beat", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 2);
    check("in_ready_out", int'(in_ready), 0);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_after_hs", int'(out_valid), 0);
    check("ready_after_hs", int'(in_ready), 1);
  endtask

  initial begin
    // n, data, per-beat approx_en, per-beat thresh, then expectations (8-bit, 5-bit)
    vecs[0] = '{1, '{18'h3FFFF, 0, 0, 0}, '{0, 0, 0, 0}, '{10, 0, 0, 0},
                18, 1, 0, 18, 0, 0};
    vecs[1] = '{3, '{18'h3FFFF, 18'h00001, 18'h00000, 0}, '{0, 0, 0, 0}, '{20, 20, 20, 0},
                19, 0, 0, 19, 0, 0};
    vecs[2] = '{2, '{18'h0007F, 18'h0001F, 0, 0}, '{1, 1, 0, 0}, '{8, 8, 0, 0},
                8, 1, 0, 8, 0, 0};
    vecs[3] = '{2, '{18'h0007F, 18'h0001F, 0, 0}, '{0, 0, 0, 0}, '{8, 8, 0, 0},
                12, 1, 0, 12, 0, 0};
    vecs[4] = '{2, '{18'h3FFFF, 18'h3FFFF, 0, 0}, '{0, 0, 0, 0}, '{36, 36, 0, 0},
                36, 1, 0, 31, 1, 1};
    vecs[5] = '{2, '{18'h3FFFF, 18'h3FFFF, 0, 0}, '{0, 0, 0, 0}, '{37, 37, 0, 0},
                36, 0, 0, 31, 1, 1};
    vecs[6] = '{1, '{18'h00000, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0},
                0, 1, 0, 0, 0, 0};
    vecs[7] = '{2, '{18'h0007F, 18'h0001F, 0, 0}, '{1, 0, 0, 0}, '{9, 0, 0, 0},
                8, 0, 0, 8, 0, 0};
    vecs[8] = '{2, '{18'h0007F, 18'h0001F, 0, 0}, '{0, 1, 0, 0}, '{12, 13, 0, 0},
                12, 1, 0, 12, 0, 0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    approx_en = 1'b0; thresh = '0; thresh5 = 5'd31; out_ready = 1'b0;
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_fire", int'(out_fire), 0);
    check("rst_out_sat", int'(out_sat), 0);
    #5 rst_n = 1'b1;
    #1 check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      for (int b = 0; b < vecs[v].n; b++)
        beat(vecs[v].data[b], (b == vecs[v].n - 1), vecs[v].apx[b], vecs[v].thr[b]);
      wait_out();
      check($sformatf("v%0d_sum", v), int'(out_sum), vecs[v].exp_sum);
      check($sformatf("v%0d_fire", v), int'(out_fire), int'(vecs[v].exp_fire));
      check($sformatf("v%0d_sat", v), int'(out_sat), int'(vecs[v].exp_sat));
      check($sformatf("v%0d_sum5", v), int'(s5_out_sum), vecs[v].exp5_sum);
      check($sformatf("v%0d_fire5", v), int'(s5_out_fire), int'(vecs[v].exp5_fire));
      check($sformatf("v%0d_sat5", v), int'(s5_out_sat), int'(vecs[v].exp5_sat));
      handshake();
    end

    // Backpressure: result held, incoming beats refused.
    beat(18'h00003, 1'b1, 1'b0, 8'd1);
    wait_out();
    in_valid = 1'b1; in_data = 18'h3FFFF; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_valid", int'(out_valid), 1);
      check("bp_sum", int'(out_sum), 2);
      check("bp_fire", int'(out_fire), 1);
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_data = 18'h00001;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_hs_valid", int'(out_valid), 0);
    check("bp_hs_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_taken", int'(in_ready), 0);
    wait_out();
    check("bp_next_sum", int'(out_sum), 1);
    handshake();

    // Reset mid-frame after 2 of 3 beats.
    beat(18'h3FFFF, 1'b0, 1'b0, 8'd5);
    beat(18'h3FFFF, 1'b0, 1'b0, 8'd5);
    rst_n = 1'b0;
    #3;
    check("mrst_valid", int'(out_valid), 0);
    check("mrst_sum", int'(out_sum), 0);
    check("mrst_fire", int'(out_fire), 0);
    check("mrst_sat", int'(out_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mrst_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    beat(18'h00003, 1'b1, 1'b0, 8'd3);
    wait_out();
    check("mrst_fresh_sum", int'(out_sum), 2);
    check("mrst_fresh_fire", int'(out_fire), 0);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
